micro_sequencer: RTL and testbench

Next-state engine of the microprogrammed control unit. It owns the 7-bit control-state register, whose output drives the microstore's `currentState` input. Each cycle it computes the following state from three sources: the microstore's sequencing fields, the instruction register (opcode dispatch), and datapath/memory status. It also supervises memory-wait states with a timeout.

---
 rtl/micro_sequencer.sv | 148 ++++++++++++++
 tb/tb_micro_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Next-state engine of the microprogrammed control unit: owns the control-state
// register, dispatches on the instruction register and supervises MOC waits.
module micro_sequencer #(
    parameter int                 STATE_W       = 7,
    parameter logic [STATE_W-1:0] RESET_STATE   = 7'd0,
    parameter logic [STATE_W-1:0] FETCH_STATE   = 7'd1,
    parameter logic [STATE_W-1:0] ILLEGAL_STATE = 7'd5,
    parameter int                 MOC_TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         next_sel,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [STATE_W-1:0] cr_target,
    input  logic [31:0]        ir,
    input  logic               moc,
    input  logic               alu_zero,
    input  logic               alu_neg,
    output logic [STATE_W-1:0] state,
    output logic               mem_timeout
);

    localparam int CNT_BITS = $clog2(MOC_TIMEOUT + 1);
    localparam int CNT_W    = (CNT_BITS < 4) ? 4 : CNT_BITS;

    localparam logic [2:0] SEL_DISPATCH = 3'b000;
    localparam logic [2:0] SEL_FETCH    = 3'b001;
    localparam logic [2:0] SEL_JUMP     = 3'b010;
    localparam logic [2:0] SEL_NEXT     = 3'b011;
    localparam logic [2:0] SEL_BRANCH   = 3'b100;
    localparam logic [2:0] SEL_WAIT     = 3'b101;
    localparam logic [2:0] SEL_HOLD     = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [STATE_W-1:0] state_inc;
    logic               cond_raw;
    logic               cond;
    logic [STATE_W-1:0] dispatch_state;
    logic               ir_unused;

    // Only opcode and funct take part in dispatch; the register fields are ignored.
    assign ir_unused = ^ir[25:6];

    function automatic logic [STATE_W-1:0] decode(input logic [5:0] opcode,
                                                  input logic [5:0] funct);
        logic [STATE_W-1:0] tgt;
        tgt = ILLEGAL_STATE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: tgt = STATE_W'(6);
                    FN_SUBU: tgt = STATE_W'(16);
                    FN_AND:  tgt = STATE_W'(19);
                    FN_OR:   tgt = STATE_W'(20);
                    FN_SLT:  tgt = STATE_W'(21);
                    FN_JR:   tgt = STATE_W'(12);
                    default: tgt = ILLEGAL_STATE;
                endcase
            end
            OP_ADDIU: tgt = STATE_W'(17);
            OP_ANDI:  tgt = STATE_W'(23);
            OP_ORI:   tgt = STATE_W'(25);
            OP_LUI:   tgt = STATE_W'(22);
            OP_LW:    tgt = STATE_W'(7);
            OP_SW:    tgt = STATE_W'(13);
            OP_BEQ:   tgt = STATE_W'(11);
            OP_J:     tgt = STATE_W'(24);
            default:  tgt = ILLEGAL_STATE;
        endcase
        return tgt;
    endfunction

    always_comb begin
        dispatch_state = decode(ir[31:26], ir[5:0]);
        state_inc      = state_q + STATE_W'(1);

        cond_raw = 1'b1;
        case (cond_sel)
            2'b00:   cond_raw = moc;
            2'b01:   cond_raw = alu_zero;
            2'b10:   cond_raw = alu_neg;
            default: cond_raw = 1'b1;
        endcase
        cond = cond_raw ^ cond_inv;
    end

    // The wait counter only survives consecutive unsatisfied waits; every other select clears it.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        case (next_sel)
            SEL_DISPATCH: state_d = dispatch_state;
            SEL_FETCH:    state_d = FETCH_STATE;
            SEL_JUMP:     state_d = cr_target;
            SEL_NEXT:     state_d = state_inc;
            SEL_BRANCH:   state_d = cond ? cr_target : state_inc;
            SEL_WAIT: begin
                if (cond) begin
                    state_d = state_inc;
                end else if (wait_cnt_q == CNT_W'(MOC_TIMEOUT)) begin
                    state_d       = ILLEGAL_STATE;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            SEL_HOLD:     state_d = state_q;
            default:      state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RESET_STATE;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random microinstruction
// streams, all compared against a behavioural next-state model.
module tb_micro_sequencer;

    logic        clk;
    logic        reset;
    logic [2:0]  next_sel;
    logic [1:0]  cond_sel;
    logic        cond_inv;
    logic [6:0]  cr_target;
    logic [31:0] ir;
    logic        moc;
    logic        alu_zero;
    logic        alu_neg;
    logic [6:0]  state;
    logic        mem_timeout;

    int pass_cnt;
    int total_cnt;

    int m_state;
    int m_cnt;
    bit m_flag;

    int op_map[int];
    int funct_map[int];

    micro_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .next_sel   (next_sel),
        .cond_sel   (cond_sel),
        .cond_inv   (cond_inv),
        .cr_target  (cr_target),
        .ir         (ir),
        .moc        (moc),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .state      (state),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_decode(input logic [31:0] word);
        int op;
        int fn;
        op = int'(word[31:26]);
        fn = int'(word[5:0]);
        if (op == 0) return funct_map.exists(fn) ? funct_map[fn] : 5;
        return op_map.exists(op) ? op_map[op] : 5;
    endfunction

    // Advance the model by one microinstruction using the inputs currently driven.
    task automatic model_step();
        bit c;
        int inc;
        case (cond_sel)
            2'd0: c = moc;
            2'd1: c = alu_zero;
            2'd2: c = alu_neg;
            default: c = 1'b1;
        endcase
        c   = c ^ cond_inv;
        inc = (m_state + 1) % 128;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_flag = 0;
        end else if (next_sel == 3'd5) begin
            if (c) begin
                m_state = inc; m_cnt = 0;
            end else if (m_cnt == 15) begin
                m_state = 5; m_flag = 1; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_cnt = 0;
            case (next_sel)
                3'd0: m_state = model_decode(ir);
                3'd1: m_state = 1;
                3'd2: m_state = int'(cr_target);
                3'd3: m_state = inc;
                3'd4: m_state = c ? int'(cr_target) : inc;
                3'd6: m_state = m_state;
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; next_sel = 3'd6; cond_sel = 2'd0; cond_inv = 0;
        cr_target = '0; ir = '0; moc = 0; alu_zero = 0; alu_neg = 0;
    endtask

    task automatic jump_to(input int s);
        next_sel = 3'd2; cr_target = 7'(s);
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; next_sel = 3'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (state !== 7'(m_state) || mem_timeout !== m_flag)
                $display("FAIL reset_hold[%0d]: state=%0d timeout=%b expected %0d/%b", i, state, mem_timeout, m_state, m_flag);
            else pass_cnt++;
        end
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (state !== 7'(m_state) || state !== 7'(i + 1))
                $display("FAIL fetch_seq[%0d]: state=%0d expected %0d", i, state, i + 1);
            else pass_cnt++;
        end
    endtask

    task automatic test_dispatch();
        logic [31:0] vec [0:14];
        vec = '{32'h8C220004, 32'h00221821, 32'hFC000000, 32'h00221823, 32'h00221824,
                32'h00221825, 32'h0022182A, 32'h03E00008, 32'h2422FFFF, 32'h3042000F,
                32'h34420001, 32'h3C021234, 32'hAC220004, 32'h10220003, 32'h0022183F};
        next_sel = 3'd0;
        foreach (vec[i]) begin
            ir = vec[i];
            tick();
            total_cnt++;
            if (state !== 7'(m_state))
                $display("FAIL dispatch ir=%h: state=%0d expected %0d", vec[i], state, m_state);
            else pass_cnt++;
        end
        ir = 32'h08000010;
        tick();
        total_cnt++;
        if (state !== 7'd24) $display("FAIL dispatch_j: state=%0d expected 24", state);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        bit zs [0:2];
        bit iv [0:2];
        zs = '{1'b1, 1'b0, 1'b0};
        iv = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cond_inv = 0;
            jump_to(11);
            next_sel = 3'd4; cond_sel = 2'd1; cr_target = 7'd26;
            alu_zero = zs[i]; cond_inv = iv[i];
            tick();
            total_cnt++;
            if (state !== 7'(m_state))
                $display("FAIL branch[%0d]: state=%0d expected %0d", i, state, m_state);
            else pass_cnt++;
        end
        cond_inv = 0; alu_zero = 0;
        jump_to(40);
        next_sel = 3'd4; cond_sel = 2'd2; alu_neg = 1; cr_target = 7'd90;
        tick();
        total_cnt++;
        if (state !== 7'd90) $display("FAIL branch_neg: state=%0d expected 90", state);
        else pass_cnt++;
        alu_neg = 0;
    endtask

    task automatic test_moc_wait();
        jump_to(30);
        next_sel = 3'd5; cond_sel = 2'd0; cond_inv = 0; moc = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (state !== 7'(m_state) || state !== 7'd30)
                $display("FAIL moc_hold[%0d]: state=%0d expected 30", i, state);
            else pass_cnt++;
        end
        moc = 1;
        tick();
        total_cnt++;
        if (state !== 7'd31) $display("FAIL moc_advance: state=%0d expected 31", state);
        else pass_cnt++;
        // Counter must restart: 10 holds, a one-cycle pulse, then 15 more holds with no timeout.
        moc = 0;
        for (int i = 0; i < 10; i++) tick();
        moc = 1; tick(); moc = 0;
        for (int i = 0; i < 15; i++) tick();
        total_cnt++;
        if (state !== 7'd32 || mem_timeout !== 1'b0 || state !== 7'(m_state))
            $display("FAIL moc_cnt_clear: state=%0d timeout=%b expected 32/0", state, mem_timeout);
        else pass_cnt++;
        moc = 1; tick(); moc = 0;
        // cond arriving on the would-be timeout edge wins.
        for (int i = 0; i < 15; i++) tick();
        moc = 1; tick(); moc = 0;
        total_cnt++;
        if (state !== 7'd34 || mem_timeout !== 1'b0)
            $display("FAIL cond_beats_timeout: state=%0d timeout=%b expected 34/0", state, mem_timeout);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        jump_to(40);
        next_sel = 3'd5; cond_sel = 2'd0; cond_inv = 0; moc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            total_cnt++;
            if (state !== 7'd40 || mem_timeout !== 1'b0)
                $display("FAIL timeout_wait[%0d]: state=%0d timeout=%b expected 40/0", i, state, mem_timeout);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (state !== 7'd5 || mem_timeout !== 1'b1 || state !== 7'(m_state))
            $display("FAIL timeout_fire: state=%0d timeout=%b expected 5/1", state, mem_timeout);
        else pass_cnt++;
        next_sel = 3'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (mem_timeout !== 1'b1 || state !== 7'(6 + i))
                $display("FAIL timeout_sticky[%0d]: state=%0d timeout=%b expected %0d/1", i, state, mem_timeout, 6 + i);
            else pass_cnt++;
        end
        reset = 1; tick(); reset = 0;
        total_cnt++;
        if (state !== 7'd0 || mem_timeout !== 1'b0)
            $display("FAIL timeout_reset: state=%0d timeout=%b expected 0/0", state, mem_timeout);
        else pass_cnt++;
    endtask

    task automatic test_wrap_reserved();
        jump_to(127);
        next_sel = 3'd3; tick();
        total_cnt++;
        if (state !== 7'd0) $display("FAIL wrap: state=%0d expected 0", state);
        else pass_cnt++;
        jump_to(50);
        next_sel = 3'd7; tick();
        total_cnt++;
        if (state !== 7'd0) $display("FAIL reserved: state=%0d expected 0", state);
        else pass_cnt++;
        jump_to(60);
        next_sel = 3'd5; cond_sel = 2'd0; moc = 0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1; next_sel = 3'd2; cr_target = 7'd20; tick(); reset = 0;
        total_cnt++;
        if (state !== 7'd0 || mem_timeout !== 1'b0)
            $display("FAIL reset_priority: state=%0d expected 0", state);
        else pass_cnt++;
        // Counter must have been cleared by the reset.
        jump_to(70);
        next_sel = 3'd5;
        for (int i = 0; i < 15; i++) tick();
        total_cnt++;
        if (state !== 7'd70 || mem_timeout !== 1'b0)
            $display("FAIL reset_clears_cnt: state=%0d timeout=%b expected 70/0", state, mem_timeout);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] known [0:5];
        known = '{32'h8C000000, 32'hAC000000, 32'h00000021, 32'h0000002A, 32'h3C000000, 32'h10000000};
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            next_sel  = ($urandom_range(0, 2) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
            cond_sel  = 2'($urandom_range(0, 3));
            cond_inv  = ($urandom_range(0, 3) == 0);
            cr_target = 7'($urandom_range(0, 127));
            ir        = ($urandom_range(0, 1) == 0) ? (known[$urandom_range(0, 5)] | ($urandom() & 32'h03FFFFC0))
                                                   : $urandom();
            moc       = ($urandom_range(0, 9) == 0);
            alu_zero  = 1'($urandom_range(0, 1));
            alu_neg   = 1'($urandom_range(0, 1));
            tick();
            total_cnt++;
            if (state !== 7'(m_state) || mem_timeout !== m_flag)
                $display("FAIL random[%0d]: state=%0d timeout=%b expected %0d/%b", n, state, mem_timeout, m_state, m_flag);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        m_state = 0; m_cnt = 0; m_flag = 0;
        funct_map[33] = 6;  funct_map[35] = 16; funct_map[36] = 19;
        funct_map[37] = 20; funct_map[42] = 21; funct_map[8]  = 12;
        op_map[9]  = 17; op_map[12] = 23; op_map[13] = 25; op_map[15] = 22;
        op_map[35] = 7;  op_map[43] = 13; op_map[4]  = 11; op_map[2]  = 24;
        idle_inputs();
        test_reset();
        test_dispatch();
        test_branch();
        test_moc_wait();
        test_timeout();
        test_wrap_reserved();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
